// File: rtl/ram_target.sv
// ram_target: Wishbone-style single-port RAM responder with programmable wait
// states, byte-lane writes and registered read data gated by acknowledge.
module ram_target #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             x_cyc,
    input  logic             x_we,
    input  logic [3:0]       x_sel,
    input  logic [WIDTH-1:0] x_adr,
    input  logic [31:0]      x_dat,
    output logic             x_ack,
    output logic [31:0]      x_rdt,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic             commit, commit_en;
    logic [WIDTH-1:0] adr_q;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic [WIDTH-1:0] cmd_adr;
    logic             cmd_we;
    logic [3:0]       cmd_sel;
    logic [31:0]      cmd_dat;
    logic [AW-1:0]    idx;
    logic             in_range;
    logic             rd_ok;
    logic [31:0]      rd_word;
    logic [31:0]      mem [DEPTH];

    // With WAIT=0 the commit happens straight from IDLE, before the request is latched.
    assign cmd_adr   = (state == ST_IDLE) ? x_adr : adr_q;
    assign cmd_we    = (state == ST_IDLE) ? x_we  : we_q;
    assign cmd_sel   = (state == ST_IDLE) ? x_sel : sel_q;
    assign cmd_dat   = (state == ST_IDLE) ? x_dat : dat_q;
    assign idx       = cmd_adr[AW-1:0];
    assign in_range  = ({1'b0, cmd_adr} < (WIDTH+1)'(DEPTH));
    assign commit_en = commit && wb_rst_n;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (x_cyc) begin
                    cnt_next = 4'(WAIT);
                    if (WAIT == 0) begin
                        state_next = ST_ACK;
                        commit     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!x_cyc) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_next = ST_ACK;
                        commit     = 1'b1;
                    end
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= 4'd0;
            dat_q <= 32'd0;
            rd_ok <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == ST_IDLE && x_cyc) begin
                adr_q <= x_adr;
                we_q  <= x_we;
                sel_q <= x_sel;
                dat_q <= x_dat;
            end
            if (commit_en) begin
                rd_ok <= !cmd_we && in_range;
            end else if (state == ST_ACK) begin
                rd_ok <= 1'b0;
            end
        end
    end

    // Storage has no reset so it maps onto a block RAM with a registered read port.
    always_ff @(posedge wb_clk) begin
        if (commit_en && in_range) begin
            if (cmd_we) begin
                for (int n = 0; n < 4; n++) begin
                    if (cmd_sel[n]) begin
                        mem[idx][8*n +: 8] <= cmd_dat[8*n +: 8];
                    end
                end
            end else begin
                rd_word <= mem[idx];
            end
        end
    end

    assign x_ack = (state == ST_ACK);
    assign busy  = (state != ST_IDLE);
    assign x_rdt = (state == ST_ACK && rd_ok) ? rd_word : 32'd0;
endmodule

// File: tb/tb_ram_target.sv
// Directed bench for ram_target: three instances (WAIT=1 with a short depth,
// WAIT=3 for aborts, WAIT=0 for back-to-back traffic) checked cycle by cycle.
module tb_ram_target;
    logic        clk;
    logic        rst_n;
    logic        cyc  [3];
    logic        we   [3];
    logic [3:0]  sel  [3];
    logic [9:0]  adr  [3];
    logic [31:0] dat  [3];
    logic        ack  [3];
    logic [31:0] rdt  [3];
    logic        busy [3];

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt [3] = '{0, 0, 0};
    int lat_req [3] = '{2, 4, 1};

    ram_target #(.WIDTH(10), .DEPTH(512), .WAIT(1)) u_w1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .x_cyc(cyc[0]), .x_we(we[0]), .x_sel(sel[0]),
        .x_adr(adr[0]), .x_dat(dat[0]), .x_ack(ack[0]), .x_rdt(rdt[0]), .busy(busy[0])
    );
    ram_target #(.WIDTH(10), .DEPTH(1024), .WAIT(3)) u_w3 (
        .wb_clk(clk), .wb_rst_n(rst_n), .x_cyc(cyc[1]), .x_we(we[1]), .x_sel(sel[1]),
        .x_adr(adr[1]), .x_dat(dat[1]), .x_ack(ack[1]), .x_rdt(rdt[1]), .busy(busy[1])
    );
    ram_target #(.WIDTH(10), .DEPTH(1024), .WAIT(0)) u_w0 (
        .wb_clk(clk), .wb_rst_n(rst_n), .x_cyc(cyc[2]), .x_we(we[2]), .x_sel(sel[2]),
        .x_adr(adr[2]), .x_dat(dat[2]), .x_ack(ack[2]), .x_rdt(rdt[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every acknowledge on every instance is counted, so spurious acks show up in the totals.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1) ack_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete classic cycle; request inputs are scrambled while waiting to prove they were latched.
    task automatic txn(input int k, input logic w, input logic [3:0] s, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic [31:0] got;
        lat = -1;
        got = 'x;
        @(negedge clk);
        cyc[k] = 1'b1;
        we[k]  = w;
        sel[k] = s;
        adr[k] = a;
        dat[k] = d;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, " busy"}, 32'(busy[k]), 32'd1);
            if (ack[k] === 1'b1) begin
                lat    = n;
                got    = rdt[k];
                cyc[k] = 1'b0;
                break;
            end
            check({tag, " rdt before ack"}, rdt[k], 32'd0);
            adr[k] = ~a;
            dat[k] = ~d;
            sel[k] = ~s;
            we[k]  = ~w;
        end
        cyc[k] = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(lat_req[k]));
        check({tag, " rdt at ack"}, got, exp_rd);
        @(negedge clk);
        check({tag, " ack drop"}, 32'(ack[k]), 32'd0);
        check({tag, " rdt clear"}, rdt[k], 32'd0);
    endtask

    logic [9:0]  b_adr [16];
    logic [31:0] b_dat [16];

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 1'b0;
            we[k]  = 1'b0;
            sel[k] = 4'h0;
            adr[k] = 10'd0;
            dat[k] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check("reset ack", 32'(ack[0]), 32'd0);
        check("reset rdt", rdt[0], 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset busy w0", 32'(busy[2]), 32'd0);
        rst_n = 1'b1;

        txn(0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 32'd0, "w5");
        txn(0, 1'b0, 4'hF, 10'd5, 32'd0, 32'hDEADBEEF, "r5");
        txn(0, 1'b1, 4'h5, 10'd5, 32'h11223344, 32'd0, "wlane");
        txn(0, 1'b0, 4'hF, 10'd5, 32'd0, 32'hDE22BE44, "rlane");
        txn(0, 1'b1, 4'h0, 10'd5, 32'hFFFFFFFF, 32'd0, "wsel0");
        txn(0, 1'b0, 4'hF, 10'd5, 32'd0, 32'hDE22BE44, "rsel0");

        txn(0, 1'b1, 4'hF, 10'd511, 32'hA5A5A5A5, 32'd0, "wtop");
        txn(0, 1'b0, 4'hF, 10'd511, 32'd0, 32'hA5A5A5A5, "rtop");
        txn(0, 1'b1, 4'hF, 10'd0, 32'h01020304, 32'd0, "w0");
        txn(0, 1'b1, 4'hF, 10'd512, 32'hFFFFFFFF, 32'd0, "woor");
        txn(0, 1'b0, 4'hF, 10'd0, 32'd0, 32'h01020304, "ralias");
        txn(0, 1'b0, 4'hF, 10'd512, 32'd0, 32'd0, "roor");

        // Abort: cycle dropped in the second wait cycle of a WAIT=3 write.
        txn(1, 1'b1, 4'hF, 10'd7, 32'd0, 32'd0, "w7zero");
        @(negedge clk);
        cyc[1] = 1'b1;
        we[1]  = 1'b1;
        sel[1] = 4'hF;
        adr[1] = 10'd7;
        dat[1] = 32'hCAFEF00D;
        @(negedge clk);
        check("abort busy", 32'(busy[1]), 32'd1);
        @(negedge clk);
        cyc[1] = 1'b0;
        repeat (6) @(negedge clk);
        check("abort idle", 32'(busy[1]), 32'd0);
        check("abort no ack", 32'(ack_cnt[1]), 32'd1);
        txn(1, 1'b0, 4'hF, 10'd7, 32'd0, 32'd0, "r7");

        // Reset pulled during the wait state of a write must leave memory untouched.
        txn(0, 1'b1, 4'hF, 10'd3, 32'h12345678, 32'd0, "w3");
        @(negedge clk);
        cyc[0] = 1'b1;
        we[0]  = 1'b1;
        sel[0] = 4'hF;
        adr[0] = 10'd3;
        dat[0] = 32'hFFFF0000;
        @(negedge clk);
        check("rst busy before", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst ack", 32'(ack[0]), 32'd0);
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst rdt", rdt[0], 32'd0);
        @(negedge clk);
        cyc[0] = 1'b0;
        rst_n  = 1'b1;
        txn(0, 1'b0, 4'hF, 10'd3, 32'd0, 32'h12345678, "r3");

        // Back-to-back traffic alternating between two initiators, WAIT=0.
        for (int i = 0; i < 16; i++) begin
            b_adr[i] = 10'(i * 37 + 2);
            b_dat[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
            txn(2, 1'b1, 4'hF, b_adr[i], b_dat[i], 32'd0, $sformatf("portA w%0d", i));
            txn(2, 1'b0, 4'hF, b_adr[i], 32'd0, b_dat[i], $sformatf("portB r%0d", i));
        end
        for (int i = 15; i >= 0; i--) begin
            txn(2, 1'b0, 4'hF, b_adr[i], 32'd0, b_dat[i], $sformatf("reread %0d", i));
        end

        repeat (3) @(negedge clk);
        check("ack total w1", 32'(ack_cnt[0]), 32'd14);
        check("ack total w3", 32'(ack_cnt[1]), 32'd2);
        check("ack total w0", 32'(ack_cnt[2]), 32'd48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_target.md
# ram_target

Wishbone-style single-port RAM responder: the target that sits on the shared X port downstream of the two-initiator RAM arbiter. It accepts classic (non-pipelined) read and write cycles and applies byte-lane selects on writes. It inserts a programmable number of wait states, then returns a single-cycle acknowledge with registered read data. Storage is an inferred synchronous block RAM of `DEPTH` 32-bit words.

## Interface
- `WIDTH`, 10: word-address width of `x_adr`.
- `DEPTH`, 1024: number of implemented words, where DEPTH ≤ 2^WIDTH. Addresses ≥ DEPTH are out of range.
- `WAIT`, 1: wait states inserted before ack, range 0..15.

Ports:
- `wb_clk` in 1: the single clock.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `x_cyc` in 1: cycle request. Held high by the initiator until it sees ack.
- `x_we` in 1: 1 = write, 0 = read.
- `x_sel` in 4: byte-lane enables. Bit n covers `x_dat[8n+7:8n]`.
- `x_adr` in WIDTH: word address.
- `x_dat` in 32: write data.
- `x_ack` out 1: single-cycle acknowledge.
- `x_rdt` out 32: read data. Valid only while `x_ack` is high and the cycle is a read; 0 otherwise.
- `busy` out 1: high in WAIT and ACK states.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE:
  - Sample `x_cyc` on each edge.
  - If high, latch `x_adr`, `x_we`, `x_sel` and `x_dat`, and load the wait counter with WAIT.
  - Go to WAIT if WAIT > 0, else go to ACK.
- WAIT:
  - Decrement the counter each cycle.
  - If `x_cyc` is low at any edge, abort: return to IDLE with no ack, no write, and `x_rdt` stays 0.
  - When the counter reaches 1 with `x_cyc` still high, go to ACK.
- Commit on entry to ACK:
  - Write: for each n with `sel[n]`=1, byte n of `mem[adr]` takes byte n of the latched data.
  - Read: `x_rdt` is loaded from `mem[adr]`.
- ACK: `x_ack`=1 for exactly one cycle. The next state is always IDLE, with no dependency on `x_cyc`.
- The initiator drops `x_cyc` on the edge where it samples ack, so IDLE sees `x_cyc` low next cycle. If `x_cyc` is still high in IDLE, that is a new request and a new transaction starts.
- Write with `sel`=0: acked, memory unchanged.
- Out-of-range address (`adr` ≥ DEPTH):
  - Write: acked, no memory change.
  - Read: acked, `x_rdt`=0.
- Read-data gating:
  - During a write ack, `x_rdt`=0.
  - `x_rdt` is cleared to 0 on the edge leaving ACK.
- Request inputs are latched only in IDLE. Changes to them in WAIT are ignored.
- Memory contents are not reset and are undefined until written. The bench must not rely on initial values.

## Timing
- Reset values, asynchronous on `wb_rst_n` low: state IDLE, counter 0, `x_ack`=0, `x_rdt`=0, `busy`=0.
- Reset asserted mid-transaction: state goes to IDLE at once and no ack is issued. A write not yet committed (still in WAIT) is never committed.
- Let cycle 0 be the first cycle with `x_cyc` high in IDLE.
  - `busy` is high from cycle 1.
  - `x_ack` is high in cycle 1+WAIT only.
  - Write data is visible to a read issued from cycle 2+WAIT onward.
- Minimum transaction spacing is 2+WAIT cycles: one IDLE sample cycle plus WAIT cycles plus the ACK cycle.
- Abort: `x_cyc` low in any WAIT cycle returns the block to IDLE at the next edge with no ack.
- Dropping `x_cyc` during the ACK cycle has no effect. The commit has already happened.
- WAIT=0: ack arrives one cycle after the request. No WAIT state is visited.

## Test plan
- Reset, then WAIT=1: write adr=5, dat=0xDEADBEEF, sel=0xF. Then read adr=5. Required: ack in cycle 2 of each transaction, and the read returns `x_rdt`=0xDEADBEEF during ack, 0 otherwise.
- Byte lanes: write adr=5 dat=0x11223344 sel=0x5, then read adr=5. Required: 0xDE22BE44.
- Abort: WAIT=3, write adr=7 dat=0xCAFEF00D, drop `x_cyc` after 2 cycles. Required: no ack. Writing 0 to adr=7 before the aborted write and reading it back afterwards returns 0.
- Range and zero-select:
  - Read adr=DEPTH-1 after writing 0xA5A5A5A5: returns 0xA5A5A5A5.
  - Write to adr=DEPTH (when DEPTH < 2^WIDTH): acked, and no alias change at adr=0.
  - Write with sel=0: acked, data unchanged.
- Reset mid-operation: pull `wb_rst_n` low during WAIT of a write to adr=3. Required: `x_ack` and `busy` go 0 immediately, and the prior value at adr=3 is preserved.
- Back-to-back through the arbiter: ports A and B alternately write and read 16 addresses, WAIT=0. Required: every cycle acked exactly once, data matches a reference model, and there are no spurious acks while `x_cyc`=0.
